// File: rtl/sc_mac_s2b_window_if.sv
// sc_mac_s2b_window_if: control, bitstream and result handshake bundle for the S2B window converter
interface sc_mac_s2b_window_if #(
    parameter int WIN_LOG2   = 8,
    parameter int SCALE_LOG2 = 4
);
    logic                         start;
    logic                         abort;
    logic                         in_bit;
    logic                         load_o;
    logic                         busy;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIN_LOG2:0]            out_count;
    logic [WIN_LOG2+SCALE_LOG2:0] out_scaled;
    modport master (
        input  start, abort, in_bit, out_ready,
        output load_o, busy, out_valid, out_count, out_scaled
    );
    modport slave (
        output start, abort, in_bit, out_ready,
        input  load_o, busy, out_valid, out_count, out_scaled
    );
endinterface

// File: rtl/sc_mac_s2b_window.sv
// sc_mac_s2b_window: loads the MAC, skips its warm-up, counts ones over 2^WIN_LOG2 cycles, hands out count and rescaled count
module sc_mac_s2b_window #(
    parameter int WIN_LOG2   = 8,
    parameter int SCALE_LOG2 = 4,
    parameter int WARMUP     = 2
) (
    input logic                 clk,
    input logic                 rst,
    sc_mac_s2b_window_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WARM = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [3:0] WARM_LAST = 4'(WARMUP > 0 ? WARMUP - 1 : 0);

    logic [2:0]          state, nxt;
    logic [3:0]          warm_cnt;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   acc, acc_nxt;

    // Next state and running sum; abort beats every other exit from a busy state
    always_comb begin
        acc_nxt = acc + (WIN_LOG2+1)'(bus.in_bit);
        nxt = (state != S_IDLE && bus.abort)               ? S_IDLE :
              (state == S_IDLE && bus.start)               ? S_LOAD :
              (state == S_LOAD)                            ? (WARMUP > 0 ? S_WARM : S_ACC) :
              (state == S_WARM && warm_cnt == WARM_LAST)   ? S_ACC  :
              (state == S_ACC && &win_cnt)                 ? S_HOLD :
              (state == S_HOLD && bus.out_ready)           ? S_IDLE : state;
    end

    // All outputs are registered from the next state so nothing passes combinationally to a port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            warm_cnt       <= '0;
            win_cnt        <= '0;
            acc            <= '0;
            bus.load_o     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_count  <= '0;
            bus.out_scaled <= '0;
        end else begin
            state         <= nxt;
            warm_cnt      <= (state == S_WARM) ? warm_cnt + 4'd1 : '0;
            win_cnt       <= (state == S_ACC) ? win_cnt + WIN_LOG2'(1) : '0;
            acc           <= (state == S_ACC) ? acc_nxt : '0;
            bus.load_o    <= nxt == S_LOAD;
            bus.busy      <= nxt != S_IDLE;
            bus.out_valid <= nxt == S_HOLD;
            if (state == S_ACC && nxt == S_HOLD) begin
                bus.out_count  <= acc_nxt;
                bus.out_scaled <= {acc_nxt, {SCALE_LOG2{1'b0}}};
            end
        end
    end
endmodule
